// File: rtl/bidir_port_pkg.sv
// Shared types and constants for the bidirectional bus port controller.
package bidir_port_pkg;

  // Bus ownership phases; TURN_* are the dead cycles between owners.
  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    TURN_RX,
    RECV,
    TURN_TX
  } portState_t;

  // Turnaround counter covers TURN_CYCLES up to 15.
  localparam int TURN_W  = $clog2(16);
  // Burst counter covers MAX_BURST up to 255.
  localparam int BURST_W = 8;

  // True for the two dead-cycle states.
  function automatic logic isTurn(input portState_t s);
    return (s == TURN_RX) || (s == TURN_TX);
  endfunction

endpackage

// File: rtl/bidir_port_ctrl_bus_turn_timer.sv
// Turnaround timer: loaded on entry to a dead-cycle phase, counts down,
// and flags the last dead cycle so the FSM can move on.
module bus_turn_timer
  import bidir_port_pkg::*;
#(
  parameter int TURN_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic done
);

  logic [TURN_W-1:0] countReg;

  // Load the dead-cycle count, then count down to zero and rest there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      countReg <= '0;
    end else if (load) begin
      countReg <= TURN_W'(TURN_CYCLES);
    end else if (countReg != '0) begin
      countReg <= countReg - TURN_W'(1);
    end
  end

  // A count of one means this is the final dead cycle.
  assign done = (countReg == TURN_W'(1));

endmodule

// File: rtl/bidir_port_ctrl.sv
// Bidirectional bus port controller: drives local stream beats onto a shared
// tri-state bus, hands the bus to a peer on request with dead cycles on every
// direction change, and captures peer beats into a single hold register.
module bidir_port_ctrl
  import bidir_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_BURST   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  inout  wire  [WIDTH-1:0] bus_dq,
  output logic             bus_dir,
  output logic             bus_stb,
  input  logic             peer_req,
  output logic             peer_gnt,
  input  logic             peer_stb,
  output logic             peer_wait
);

  typedef logic [WIDTH-1:0] bus_beat_t;

  portState_t         stateReg;
  portState_t         stateNext;
  bus_beat_t          outReg;
  bus_beat_t          holdReg;
  logic               stbReg;
  logic               rxValidReg;
  logic [BURST_W-1:0] burstCount;
  logic               yieldPending;
  logic               txAccept;
  logic               rxCapture;
  logic               turnLoad;
  logic               turnDone;

  // Dead-cycle timer shared by both turnaround phases.
  bus_turn_timer #(
    .TURN_CYCLES(TURN_CYCLES)
  ) turnTimer (
    .clk (clk),
    .rst (rst),
    .load(turnLoad),
    .done(turnDone)
  );

  // Start the timer on the edge that enters either dead-cycle phase.
  assign turnLoad = isTurn(stateNext) && !isTurn(stateReg);

  // State register; reset parks the port with the bus released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and ownership outputs; direction and grant decode straight
  // from the state register so reset releases the bus without waiting a clock.
  always_comb begin
    stateNext    = stateReg;
    yieldPending = 1'b0;
    tx_ready     = 1'b0;
    bus_dir      = 1'b0;
    peer_gnt     = 1'b0;
    case (stateReg)
      IDLE: begin
        // A peer request wins over a local beat arriving on the same edge.
        if (peer_req) begin
          stateNext = TURN_RX;
        end else if (tx_valid) begin
          stateNext = DRIVE;
        end
      end
      DRIVE: begin
        bus_dir      = 1'b1;
        // Yield once the burst allowance is spent or the local stream runs dry.
        yieldPending = peer_req &&
                       ((burstCount == BURST_W'(MAX_BURST)) || !tx_valid);
        tx_ready     = !yieldPending;
        if (yieldPending) begin
          stateNext = TURN_RX;
        end
      end
      TURN_RX: begin
        if (turnDone) begin
          stateNext = RECV;
        end
      end
      RECV: begin
        peer_gnt = 1'b1;
        if (!peer_req) begin
          stateNext = TURN_TX;
        end
      end
      TURN_TX: begin
        if (turnDone) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign txAccept = tx_ready && tx_valid;

  // Launch path: an accepted beat is presented with a strobe one cycle later;
  // the last data stays on the bus while it is parked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outReg <= '0;
      stbReg <= 1'b0;
    end else begin
      stbReg <= txAccept;
      if (txAccept) begin
        outReg <= tx_data;
      end
    end
  end

  // Burst allowance only runs while the peer is waiting for the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burstCount <= '0;
    end else if ((stateReg != DRIVE) || !peer_req) begin
      burstCount <= '0;
    end else if (txAccept) begin
      burstCount <= burstCount + BURST_W'(1);
    end
  end

  // Peer must hold off while a beat is parked and the consumer is not taking it.
  assign peer_wait = rxValidReg && !rx_ready;
  // Strobes during a hold-off are dropped so the parked beat is never overwritten.
  assign rxCapture = (stateReg == RECV) && peer_stb && !peer_wait;

  // Receive hold register; drains on rx_ready regardless of bus ownership.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdReg    <= '0;
      rxValidReg <= 1'b0;
    end else if (rxCapture) begin
      holdReg    <= bus_dq;
      rxValidReg <= 1'b1;
    end else if (rx_ready) begin
      rxValidReg <= 1'b0;
    end
  end

  assign bus_stb  = stbReg;
  assign rx_valid = rxValidReg;
  assign rx_data  = holdReg;

  // Tri-state driver: this side drives only while it owns the bus.
  assign bus_dq = bus_dir ? outReg : 'z;

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed bench for bidir_port_ctrl with scoreboard queues for bus and rx beats.
module tb_bidir_port_ctrl;

  localparam int WIDTH       = 8;
  localparam int TURN_CYCLES = 2;
  localparam int MAX_BURST   = 4;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  wire  [7:0] busDq;
  logic       bus_dir;
  logic       bus_stb;
  logic       peer_req;
  logic       peer_gnt;
  logic       peer_stb;
  logic       peer_wait;

  logic       peerDrive;
  logic [7:0] peerData;

  int checks;
  int failures;
  logic [7:0] expBus[$];
  logic [7:0] expRx[$];
  logic prevDir;
  logic prevGnt;

  assign busDq = peerDrive ? peerData : 'z;

  bidir_port_ctrl #(
    .WIDTH      (WIDTH),
    .TURN_CYCLES(TURN_CYCLES),
    .MAX_BURST  (MAX_BURST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .bus_dq   (busDq),
    .bus_dir  (bus_dir),
    .bus_stb  (bus_stb),
    .peer_req (peer_req),
    .peer_gnt (peer_gnt),
    .peer_stb (peer_stb),
    .peer_wait(peer_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkByte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Offer one beat in DRIVE; it must be accepted and appear on the bus next cycle.
  task automatic sendBeat(input logic [7:0] data);
    tx_valid = 1'b1;
    tx_data  = data;
    settle();
    chkBit("tx_ready_accept", tx_ready, 1'b1);
    chkBit("bus_dir_drive", bus_dir, 1'b1);
    expBus.push_back(data);
    $display("tx beat %h issued", data);
    tick();
  endtask

  // Monitor: pops expected beats when the DUT presents them and guards the ownership invariant.
  initial begin
    logic [7:0] expVal;
    prevDir = 1'b0;
    prevGnt = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_stb) begin
        if (expBus.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bus_beat_unexpected: got %h expected none at %0t", busDq, $time);
        end else begin
          expVal = expBus.pop_front();
          chkByte("bus_beat", busDq, expVal);
          $display("bus beat %h seen, expected %h", busDq, expVal);
        end
      end
      if (rx_valid && rx_ready) begin
        if (expRx.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_beat_unexpected: got %h expected none at %0t", rx_data, $time);
        end else begin
          expVal = expRx.pop_front();
          chkByte("rx_beat", rx_data, expVal);
          $display("rx beat %h taken, expected %h", rx_data, expVal);
        end
      end
      chkBit("owner_overlap",
             (bus_dir && peer_gnt) || (bus_dir && prevGnt) || (peer_gnt && prevDir), 1'b0);
      prevDir = bus_dir;
      prevGnt = peer_gnt;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b0;
    peer_req  = 1'b0;
    peer_stb  = 1'b0;
    peerDrive = 1'b0;
    peerData  = 8'h00;

    // Reset state
    tick();
    tick();
    settle();
    chkBit("rst_bus_dir", bus_dir, 1'b0);
    chkBit("rst_bus_stb", bus_stb, 1'b0);
    chkBit("rst_peer_gnt", peer_gnt, 1'b0);
    chkBit("rst_tx_ready", tx_ready, 1'b0);
    chkBit("rst_rx_valid", rx_valid, 1'b0);
    chkBit("rst_peer_wait", peer_wait, 1'b0);
    chkByte("rst_rx_data", rx_data, 8'h00);
    chkBit("rst_bus_z", busDq === 8'hzz, 1'b1);
    rst = 1'b0;

    // IDLE with a pending local beat, then three beats
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'h11;
    settle();
    chkBit("idle_tx_ready", tx_ready, 1'b0);
    chkBit("idle_bus_dir", bus_dir, 1'b0);
    tick();
    sendBeat(8'h11);
    sendBeat(8'h22);
    sendBeat(8'h33);
    tx_valid = 1'b0;
    settle();
    chkBit("last_beat_dir", bus_dir, 1'b1);
    tick();
    settle();
    chkBit("parked_stb", bus_stb, 1'b0);
    chkBit("parked_dir", bus_dir, 1'b1);
    chkByte("parked_data", busDq, 8'h33);
    tick();

    // Peer request during a stream: exactly MAX_BURST more beats, then yield
    peer_req = 1'b1;
    for (int i = 0; i < MAX_BURST; i++) begin
      sendBeat(8'(8'h40 + i));
    end
    tx_valid = 1'b1;
    tx_data  = 8'h44;
    settle();
    chkBit("burst_limit_ready", tx_ready, 1'b0);
    chkBit("burst_limit_dir", bus_dir, 1'b1);
    tick();
    tx_valid = 1'b0;
    for (int i = 0; i < TURN_CYCLES; i++) begin
      settle();
      chkBit("turn_rx_dir", bus_dir, 1'b0);
      chkBit("turn_rx_gnt", peer_gnt, 1'b0);
      chkBit("turn_rx_bus_z", busDq === 8'hzz, 1'b1);
      tick();
    end
    settle();
    chkBit("recv_gnt", peer_gnt, 1'b1);
    chkBit("recv_dir", bus_dir, 1'b0);

    // RECV: 0xA5 held, 0x5A dropped under peer_wait, then popped
    peerDrive = 1'b1;
    peerData  = 8'hA5;
    peer_stb  = 1'b1;
    settle();
    chkBit("recv_wait_empty", peer_wait, 1'b0);
    expRx.push_back(8'hA5);
    tick();
    peerData = 8'h5A;
    settle();
    chkBit("held_valid", rx_valid, 1'b1);
    chkByte("held_data", rx_data, 8'hA5);
    chkBit("held_wait", peer_wait, 1'b1);
    tick();
    peer_stb = 1'b0;
    rx_ready = 1'b1;
    settle();
    chkBit("pop_wait", peer_wait, 1'b0);
    tick();
    rx_ready = 1'b0;
    peerData = 8'h3C;
    peer_stb = 1'b1;
    settle();
    chkBit("dropped_beat", rx_valid, 1'b0);
    expRx.push_back(8'h3C);
    tick();

    // Simultaneous pop and load
    peerData = 8'hC3;
    rx_ready = 1'b1;
    settle();
    chkBit("swap_wait", peer_wait, 1'b0);
    expRx.push_back(8'hC3);
    tick();
    peer_stb = 1'b0;
    settle();
    chkBit("swap_valid", rx_valid, 1'b1);
    chkByte("swap_data", rx_data, 8'hC3);
    tick();

    // peer_req drops with a final strobe; queued local beat follows the turnaround
    rx_ready = 1'b0;
    peer_req = 1'b0;
    peerData = 8'h77;
    peer_stb = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    settle();
    chkBit("drop_gnt_still", peer_gnt, 1'b1);
    chkBit("drop_rx_empty", rx_valid, 1'b0);
    expRx.push_back(8'h77);
    tick();
    peer_stb  = 1'b0;
    peerDrive = 1'b0;
    rx_ready  = 1'b1;
    settle();
    chkBit("turn_tx_gnt", peer_gnt, 1'b0);
    chkBit("turn_tx_dir", bus_dir, 1'b0);
    chkBit("turn_tx_ready", tx_ready, 1'b0);
    chkByte("last_strobe_data", rx_data, 8'h77);
    tick();
    rx_ready = 1'b0;
    settle();
    chkBit("turn_tx2_gnt", peer_gnt, 1'b0);
    chkBit("turn_tx2_dir", bus_dir, 1'b0);
    chkBit("turn_tx2_bus_z", busDq === 8'hzz, 1'b1);
    tick();
    settle();
    chkBit("back_idle_dir", bus_dir, 1'b0);
    chkBit("back_idle_ready", tx_ready, 1'b0);
    tick();
    sendBeat(8'h55);

    // Parked bus with no local data yields to a peer request
    tx_valid = 1'b0;
    peer_req = 1'b1;
    settle();
    chkBit("yield_idle_ready", tx_ready, 1'b0);
    tick();
    tick();
    tick();
    settle();
    chkBit("yield_recv_gnt", peer_gnt, 1'b1);
    peer_req = 1'b0;
    tick();
    tick();

    // Request and local beat both pending into IDLE: request wins
    peer_req = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hEE;
    for (int i = 0; i < 2 + TURN_CYCLES; i++) begin
      settle();
      chkBit("prio_tx_ready", tx_ready, 1'b0);
      chkBit("prio_gnt", peer_gnt, 1'b0);
      tick();
    end
    settle();
    chkBit("prio_recv_gnt", peer_gnt, 1'b1);
    chkBit("prio_recv_ready", tx_ready, 1'b0);

    // Back to DRIVE, then reset mid-operation with a beat in flight
    peer_req = 1'b0;
    tx_data  = 8'h99;
    tick();
    tick();
    tick();
    tick();
    sendBeat(8'h99);
    tx_data = 8'hAB;
    settle();
    chkBit("inflight_ready", tx_ready, 1'b1);
    tick();
    rst      = 1'b1;
    tx_valid = 1'b0;
    settle();
    chkBit("midrst_dir", bus_dir, 1'b0);
    chkBit("midrst_bus_z", busDq === 8'hzz, 1'b1);
    chkBit("midrst_stb", bus_stb, 1'b0);
    chkBit("midrst_ready", tx_ready, 1'b0);
    chkBit("midrst_gnt", peer_gnt, 1'b0);
    chkBit("midrst_rx_valid", rx_valid, 1'b0);
    chkByte("midrst_rx_data", rx_data, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    tx_valid = 1'b1;
    tx_data  = 8'hC0;
    settle();
    chkBit("post_rst_idle_ready", tx_ready, 1'b0);
    chkBit("post_rst_idle_dir", bus_dir, 1'b0);
    tick();
    sendBeat(8'hC0);
    tx_valid = 1'b0;
    tick();
    tick();
    settle();
    chkBit("bus_queue_drained", expBus.size() == 0, 1'b1);
    chkBit("rx_queue_drained", expRx.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
